// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with majority-vote bit sampling
// and a first-word-fall-through receive FIFO carrying per-word error flags.
module uart_rx_cfg #(
  parameter int OVS        = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [3:0]        recep,
  input  logic [15:0]       BaudRate,
  input  logic [1:0]        parMode,
  input  logic              stop2,
  input  logic              rxRead,
  input  logic              clrOvr,
  output logic              rxValid,
  output logic [DATA_W-1:0] rxOut,
  output logic              rxPErr,
  output logic              rxFErr,
  output logic              rxOvr,
  output logic              busy
);

  localparam int PW = $clog2(OVS);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_W + 2;

  localparam logic [PW-1:0] PH_S0  = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] PH_S1  = PW'(OVS / 2);
  localparam logic [PW-1:0] PH_S2  = PW'(OVS / 2 + 1);
  localparam logic [PW-1:0] PH_END = PW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer; rx_d keeps the previous synchronized value for edge detect
  // ---------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_d;
  logic fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order between always_ff blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  // ---------------------------------------------------------------------------
  // Oversample tick generator; restarted on start detection to align bit phase
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [15:0] baud_cnt;
  logic [15:0] baud_lim;
  logic        tick;
  logic        start_det;

  assign start_det = (state == IDLE) && fall;
  assign baud_lim  = (BaudRate == 16'd0) ? 16'd0 : BaudRate - 16'd1;
  // >= also recovers if BaudRate shrinks below the running count
  assign tick      = (baud_cnt >= baud_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
    end else if (start_det || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-length clamp
  // ---------------------------------------------------------------------------
  logic [CW-1:0] recep_c;

  // NOTE: every branch assigns recep_c, so this stays combinational (no latch).
  always_comb begin
    if (recep < 4'd5) begin
      recep_c = CW'(5);
    end else if (32'(recep) > DATA_W) begin
      recep_c = CW'(DATA_W);
    end else begin
      recep_c = CW'(recep);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     ph;
  logic [CW-1:0]     recep_l;
  logic [CW-1:0]     bit_idx;
  logic [1:0]        par_l;
  logic              stop2_l;
  logic              stop_idx;
  logic              samp0, samp1;
  logic              maj;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] bit_mask;
  logic              perr, ferr;
  logic              par_en;
  logic              push;
  logic [WW-1:0]     push_word;

  assign maj       = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);
  assign par_en    = (par_l == 2'b01) || (par_l == 2'b10);
  assign push      = (state == STOP) && tick && (ph == PH_S2) && (stop_idx == stop2_l);
  // The final stop sample is folded in here because ferr only updates at this edge
  assign push_word = {ferr | ~maj, perr, shreg};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ph       <= '0;
      recep_l  <= '0;
      bit_idx  <= '0;
      par_l    <= 2'b00;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      shreg    <= '0;
      bit_mask <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state == IDLE) begin
      if (fall) begin
        state    <= START;
        ph       <= '0;
        recep_l  <= recep_c;
        par_l    <= parMode;
        stop2_l  <= stop2;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        shreg    <= '0;
        bit_mask <= DATA_W'(1);
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end
    end else if (tick) begin
      ph <= (ph == PH_END) ? '0 : ph + PW'(1);
      if (ph == PH_S0) samp0 <= rx_s2;
      if (ph == PH_S1) samp1 <= rx_s2;

      case (state)
        START: begin
          if ((ph == PH_S2) && maj) begin
            state <= IDLE;
          end else if (ph == PH_END) begin
            state <= DATA;
          end
        end

        DATA: begin
          if ((ph == PH_S2) && maj) shreg <= shreg | bit_mask;
          if (ph == PH_END) begin
            bit_mask <= bit_mask << 1;
            bit_idx  <= bit_idx + CW'(1);
            if (bit_idx == recep_l - CW'(1)) begin
              state <= par_en ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (ph == PH_S2) perr <= ((^shreg) ^ maj) != (par_l == 2'b10);
          if (ph == PH_END) state <= STOP;
        end

        STOP: begin
          if (ph == PH_S2) begin
            if (!maj) ferr <= 1'b1;
            if (stop_idx == stop2_l) state <= IDLE;
          end
          if (ph == PH_END) stop_idx <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;
  logic          ovr;
  logic [WW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rxRead && !empty;
  // A same-cycle pop frees the slot being written, so a full push still fits
  assign wr_en = push && (!full || pop);

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // the outputs are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (push && full && !pop) begin
        ovr <= 1'b1;
      end else if (clrOvr) begin
        ovr <= 1'b0;
      end
    end
  end

  assign head                      = mem[rd_ptr[AW-1:0]];
  assign rxValid                   = !empty;
  assign {rxFErr, rxPErr, rxOut}   = empty ? '0 : head;
  assign rxOvr                     = ovr;

endmodule
